vx_mem_seq: RTL and testbench
=============================

Name: vx_mem_seq

Overview:
- Memory stage. Sits between the E/M pipeline register and the M/W pipeline register.
- Takes one warp instruction per issue and serialises its per-thread loads and stores onto a single-port data-cache interface, one active thread at a time.
- Freezes the pipeline until every active thread has completed, then presents ALU results, formatted load data and writeback control to the M/W register for one cycle.

Parameters:
- NT, 4, threads per warp. Per-thread vectors are flattened as NT*32 bits; thread i occupies bits [32i+31:32i].
- NW, 8, warps; warp_num width is log2(NW).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_alu_result  in  NT*32  per-thread ALU result; this is the effective address for memory operations.
- in_rd2  in  NT*32  per-thread store data.
- in_mem_read  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, 7 none.
- in_mem_write  in  3  store type: 0 SB, 1 SH, 2 SW, 7 none.
- in_rd / in_rs1 / in_rs2  in  5 each  register indices.
- in_wb  in  2  writeback select.
- in_PC_next  in  32  next PC.
- in_valid  in  NT  thread mask.
- in_warp_num  in  log2(NW)  warp id.
- dcache_req_valid  out  1  request valid.
- dcache_req_ready  in  1  cache accepts request.
- dcache_req_addr  out  32  word-aligned address (addr[1:0]=0).
- dcache_req_we  out  1  1 = store.
- dcache_req_be  out  4  byte enables.
- dcache_req_wdata  out  32  lane-aligned store data.
- dcache_rsp_valid  in  1  load data valid.
- dcache_rsp_data  in  32  raw load word.
- out_alu_result / out_mem_result  out  NT*32 each  to M/W.
- out_rd / out_rs1 / out_rs2 / out_wb / out_PC_next / out_valid / out_warp_num  out  as inputs  to M/W.
- out_freeze  out  1  stall to fetch through E/M and to the M/W register.

Behaviour:
- Memory instruction (is_mem): (in_mem_read!=7 or in_mem_write!=7) and in_valid!=0.
- States:
  - IDLE: on is_mem, capture all inputs plus remaining mask R=in_valid; go to REQ. Otherwise stay in IDLE.
  - REQ: serve the lowest set bit of R as thread t.
  - WAIT: waiting for load data for thread t.
  - DONE: present results for one cycle.
- IDLE with no is_mem:
  - All out_* equal their in_* combinationally.
  - out_mem_result=0, out_freeze=0, dcache_req_valid=0.
- out_freeze=1 combinationally in IDLE when is_mem is true, and in all of REQ and WAIT. out_freeze=0 in DONE.
- REQ:
  - dcache_req_valid=1; req_addr = {addr_t[31:2],2'b00}; req_we = store.
  - Store enables and data:
    - SB: be = 1<<addr[1:0]; wdata = byte replicated ×4.
    - SH: be = addr[1]?4'b1100:4'b0011; wdata = half replicated ×2.
    - SW: be = 4'hF; wdata = full word.
  - Loads drive be=4'hF.
  - On accept (valid&ready) of a store: clear R[t]. If R is now 0 go to DONE, else stay in REQ.
  - On accept of a load: go to WAIT.
  - Without ready: hold all request outputs stable.
- WAIT:
  - dcache_req_valid=0.
  - On rsp_valid: select the byte/half by the captured addr[1:0] / addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Write the formatted value to mem_result[t], clear R[t]. Go to REQ if R!=0, else DONE.
  - rsp_valid in any other state is ignored.
- DONE:
  - Outputs come from the captured registers.
  - mem_result lanes of inactive threads, and all lanes for stores, are 0.
  - Unconditionally return to IDLE next cycle.
- Misaligned LH/LW/SH/SW: no trap; the address is truncated as above.
- A response arriving in the same cycle as a request is accepted counts for the next WAIT only; the FSM never accepts a response while in REQ.
- Reset (async, mid-operation allowed) clears state to IDLE, R=0, all captured registers and mem_result to 0, dcache_req_valid=0. Outputs then follow IDLE rules.
- Latency, all NT threads active, ready=1, response one cycle after accept:
  - Load: 1 (IDLE) + 2·NT + 1 (DONE) cycles.
  - Store: 1 + NT + 1 cycles.

Test Plan:
- Non-memory instruction (in_mem_read=in_mem_write=7, in_alu_result lane0=0x55) -> out_alu_result lane0=0x55 in the same cycle, out_freeze=0, no cache request.
- LW with in_valid=4'b1011, addresses 0x100/0x104/-/0x10C, cache returns 0xA0,0xA1,0xA3 -> requests in thread order 0,1,3. DONE shows mem_result={0xA3,0,0xA1,0xA0}. Freeze high for exactly 7 cycles.
- LB at addr 0x203 with rsp 0x80FF_FF7F -> 0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LH at 0x202 -> 0xFFFF_80FF.
- SB at 0x301 with data 0x12345678, all 4 threads -> each request be=4'b0010, wdata=0x78787878, we=1. DONE reached after 4 accepts.
- dcache_req_ready held low 5 cycles in REQ -> addr/be/wdata stable, freeze stays 1. A spurious rsp_valid during REQ is ignored.
- Reset asserted in WAIT -> dcache_req_valid=0 and state IDLE immediately. After release, a new LW completes normally.

Source files
------------

// File: rtl/vx_mem_seq.sv
// Memory stage: serialises a warp's per-thread loads/stores onto a single-port
// data cache, freezing the pipeline until every active thread has completed.
//   state | meaning
//   IDLE  | pass-through; capture the warp instruction on a memory op
//   REQ   | issue request for the lowest remaining thread
//   WAIT  | waiting for load data of that thread
//   DONE  | present captured results to M/W for one cycle
module vx_mem_seq #(
    parameter int NT = 4,
    parameter int NW = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NT*32-1:0]        in_alu_result,
    input  logic [NT*32-1:0]        in_rd2,
    input  logic [2:0]              in_mem_read,
    input  logic [2:0]              in_mem_write,
    input  logic [4:0]              in_rd,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    input  logic [1:0]              in_wb,
    input  logic [31:0]             in_PC_next,
    input  logic [NT-1:0]           in_valid,
    input  logic [$clog2(NW)-1:0]   in_warp_num,
    output logic                    dcache_req_valid,
    input  logic                    dcache_req_ready,
    output logic [31:0]             dcache_req_addr,
    output logic                    dcache_req_we,
    output logic [3:0]              dcache_req_be,
    output logic [31:0]             dcache_req_wdata,
    input  logic                    dcache_rsp_valid,
    input  logic [31:0]             dcache_rsp_data,
    output logic [NT*32-1:0]        out_alu_result,
    output logic [NT*32-1:0]        out_mem_result,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [1:0]              out_wb,
    output logic [31:0]             out_PC_next,
    output logic [NT-1:0]           out_valid,
    output logic [$clog2(NW)-1:0]   out_warp_num,
    output logic                    out_freeze
);

    localparam int TW = (NT > 1) ? $clog2(NT) : 1;
    localparam int WW = $clog2(NW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic [NT*32-1:0]    r_alu;
    logic [NT*32-1:0]    r_rd2;
    logic [2:0]          r_mem_read;
    logic [2:0]          r_mem_write;
    logic [4:0]          r_rd;
    logic [4:0]          r_rs1;
    logic [4:0]          r_rs2;
    logic [1:0]          r_wb;
    logic [31:0]         r_pc;
    logic [NT-1:0]       r_valid;
    logic [WW-1:0]       r_warp;
    logic [NT-1:0]       r_rem;
    logic [NT*32-1:0]    r_mem_result;

    logic                w_is_mem;
    logic                w_is_store;
    logic [NT-1:0]       w_rem_clr;
    logic [TW-1:0]       w_thr;
    logic [31:0]         w_addr;
    logic [31:0]         w_wd;
    logic [7:0]          w_rsp_b;
    logic [15:0]         w_rsp_h;
    logic [31:0]         w_ld_data;
    logic [NT*32-1:0]    w_mem_out;

    assign w_is_mem   = ((in_mem_read != 3'd7) || (in_mem_write != 3'd7)) && (in_valid != '0);
    assign w_is_store = (r_mem_write != 3'd7);
    // Clearing the lowest set bit retires exactly the thread being served.
    assign w_rem_clr  = r_rem & (r_rem - 1'b1);

    always_comb begin
        w_thr = '0;
        for (int i = NT - 1; i >= 0; i--) begin
            if (r_rem[i]) w_thr = TW'(i);
        end
    end

    assign w_addr = r_alu[{w_thr, 5'b0} +: 32];
    assign w_wd   = r_rd2[{w_thr, 5'b0} +: 32];

    assign dcache_req_addr = {w_addr[31:2], 2'b00};
    assign dcache_req_we   = w_is_store;

    always_comb begin
        dcache_req_be    = 4'hF;
        dcache_req_wdata = '0;
        if (w_is_store) begin
            case (r_mem_write)
                3'd0: begin
                    dcache_req_be    = 4'b0001 << w_addr[1:0];
                    dcache_req_wdata = {4{w_wd[7:0]}};
                end
                3'd1: begin
                    dcache_req_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                    dcache_req_wdata = {2{w_wd[15:0]}};
                end
                default: begin
                    dcache_req_be    = 4'hF;
                    dcache_req_wdata = w_wd;
                end
            endcase
        end
    end

    assign w_rsp_b = dcache_rsp_data[{w_addr[1:0], 3'b000} +: 8];
    assign w_rsp_h = w_addr[1] ? dcache_rsp_data[31:16] : dcache_rsp_data[15:0];

    always_comb begin
        case (r_mem_read)
            3'd0:    w_ld_data = {{24{w_rsp_b[7]}}, w_rsp_b};
            3'd1:    w_ld_data = {{16{w_rsp_h[15]}}, w_rsp_h};
            3'd4:    w_ld_data = {24'd0, w_rsp_b};
            3'd5:    w_ld_data = {16'd0, w_rsp_h};
            default: w_ld_data = dcache_rsp_data;
        endcase
    end

    always_comb begin
        w_mem_out = '0;
        for (int i = 0; i < NT; i++) begin
            if (r_valid[i] && !w_is_store) w_mem_out[i*32 +: 32] = r_mem_result[i*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu        <= '0;
            r_rd2        <= '0;
            r_mem_read   <= '0;
            r_mem_write  <= '0;
            r_rd         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_wb         <= '0;
            r_pc         <= '0;
            r_valid      <= '0;
            r_warp       <= '0;
            r_rem        <= '0;
            r_mem_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        r_alu        <= in_alu_result;
                        r_rd2        <= in_rd2;
                        r_mem_read   <= in_mem_read;
                        r_mem_write  <= in_mem_write;
                        r_rd         <= in_rd;
                        r_rs1        <= in_rs1;
                        r_rs2        <= in_rs2;
                        r_wb         <= in_wb;
                        r_pc         <= in_PC_next;
                        r_valid      <= in_valid;
                        r_warp       <= in_warp_num;
                        r_rem        <= in_valid;
                        r_mem_result <= '0;
                    end
                end
                S_REQ: begin
                    if (dcache_req_ready && w_is_store) r_rem <= w_rem_clr;
                end
                S_WAIT: begin
                    if (dcache_rsp_valid) begin
                        r_mem_result[{w_thr, 5'b0} +: 32] <= w_ld_data;
                        r_rem                             <= w_rem_clr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        out_freeze       = 1'b0;
        dcache_req_valid = 1'b0;
        out_alu_result   = r_alu;
        out_mem_result   = w_mem_out;
        out_rd           = r_rd;
        out_rs1          = r_rs1;
        out_rs2          = r_rs2;
        out_wb           = r_wb;
        out_PC_next      = r_pc;
        out_valid        = r_valid;
        out_warp_num     = r_warp;
        case (r_state)
            S_IDLE: begin
                out_alu_result = in_alu_result;
                out_mem_result = '0;
                out_rd         = in_rd;
                out_rs1        = in_rs1;
                out_rs2        = in_rs2;
                out_wb         = in_wb;
                out_PC_next    = in_PC_next;
                out_valid      = in_valid;
                out_warp_num   = in_warp_num;
                if (w_is_mem) begin
                    out_freeze = 1'b1;
                    w_state_nx = S_REQ;
                end
            end
            S_REQ: begin
                out_freeze       = 1'b1;
                dcache_req_valid = 1'b1;
                if (dcache_req_ready) begin
                    if (w_is_store) w_state_nx = (w_rem_clr == '0) ? S_DONE : S_REQ;
                    else            w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                out_freeze = 1'b1;
                if (dcache_rsp_valid) w_state_nx = (w_rem_clr == '0) ? S_DONE : S_REQ;
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vx_mem_seq.sv
// Bench for vx_mem_seq: directed scenarios plus randomized warp memory ops
// checked against a thread-queue reference model.
module tb_vx_mem_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in_alu_result, in_rd2;
    logic [2:0]   in_mem_read, in_mem_write;
    logic [4:0]   in_rd, in_rs1, in_rs2;
    logic [1:0]   in_wb;
    logic [31:0]  in_PC_next;
    logic [3:0]   in_valid;
    logic [2:0]   in_warp_num;
    logic         dcache_req_valid, dcache_req_ready, dcache_req_we;
    logic [31:0]  dcache_req_addr, dcache_req_wdata;
    logic [3:0]   dcache_req_be;
    logic         dcache_rsp_valid;
    logic [31:0]  dcache_rsp_data;
    logic [127:0] out_alu_result, out_mem_result;
    logic [4:0]   out_rd, out_rs1, out_rs2;
    logic [1:0]   out_wb;
    logic [31:0]  out_PC_next;
    logic [3:0]   out_valid;
    logic [2:0]   out_warp_num;
    logic         out_freeze;

    int n_checks = 0;
    int n_errs   = 0;

    vx_mem_seq #(.NT(4), .NW(8)) dut (
        .clk(clk), .reset(reset),
        .in_alu_result(in_alu_result), .in_rd2(in_rd2),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_wb(in_wb),
        .in_PC_next(in_PC_next), .in_valid(in_valid), .in_warp_num(in_warp_num),
        .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
        .dcache_req_addr(dcache_req_addr), .dcache_req_we(dcache_req_we),
        .dcache_req_be(dcache_req_be), .dcache_req_wdata(dcache_req_wdata),
        .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_data(dcache_rsp_data),
        .out_alu_result(out_alu_result), .out_mem_result(out_mem_result),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_wb(out_wb),
        .out_PC_next(out_PC_next), .out_valid(out_valid), .out_warp_num(out_warp_num),
        .out_freeze(out_freeze)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [2:0] mw, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (mw == 3'd0) return 4'(1 << off);
        if (mw == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] mw, input logic [31:0] d);
        if (mw == 3'd0) return (d % 256) * 32'h0101_0101;
        if (mw == 3'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] mr, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (mr)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic run_mem(input logic [127:0] alu, input logic [127:0] rd2,
                           input logic [2:0] mr, input logic [2:0] mw, input logic [3:0] vm,
                           input logic [127:0] words, input int stall0, input bit rnd,
                           input int exp_frz, output logic [127:0] obs_mr);
        logic [127:0] exp_mr;
        int           q[$];
        logic [4:0]   rd, rs1, rs2;
        logic [1:0]   wb;
        logic [31:0]  pc, a;
        logic [2:0]   wn;
        int           frz, stall, wcnt, dly, t;
        bit           pend, done;
        exp_mr = '0;
        obs_mr = '0;
        for (int i = 0; i < 4; i++) if (vm[i]) q.push_back(i);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        wb = 2'($urandom); pc = $urandom; wn = 3'($urandom);
        @(negedge clk);
        in_alu_result = alu; in_rd2 = rd2; in_mem_read = mr; in_mem_write = mw;
        in_valid = vm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_wb = wb;
        in_PC_next = pc; in_warp_num = wn;
        #1;
        frz = out_freeze ? 1 : 0;
        chk("cap_freeze", 128'(out_freeze), 128'(1));
        chk("cap_req_valid", 128'(dcache_req_valid), 128'(0));
        stall = stall0; pend = 0; done = 0; wcnt = 0; dly = 1;
        @(negedge clk);
        in_mem_read = 3'd7; in_mem_write = 3'd7;
        in_alu_result = {4{$urandom}}; in_valid = 4'($urandom);
        in_rd = 5'($urandom); in_PC_next = $urandom;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            #1;
            dcache_req_ready = 1'b0;
            dcache_rsp_valid = 1'b0;
            if (out_freeze) frz++;
            if (pend) begin
                chk("wait_req_valid", 128'(dcache_req_valid), 128'(0));
                chk("wait_freeze", 128'(out_freeze), 128'(1));
                if (wcnt == dly) begin
                    t = q.pop_front();
                    a = alu[t*32 +: 32];
                    dcache_rsp_valid = 1'b1;
                    dcache_rsp_data  = words[t*32 +: 32];
                    exp_mr[t*32 +: 32] = m_load(mr, a, words[t*32 +: 32]);
                    pend = 0;
                end else wcnt++;
            end else if (q.size() != 0) begin
                t = q[0];
                a = alu[t*32 +: 32];
                chk("req_valid", 128'(dcache_req_valid), 128'(1));
                chk("req_freeze", 128'(out_freeze), 128'(1));
                chk("req_addr", 128'(dcache_req_addr), 128'(a - (a % 4)));
                chk("req_we", 128'(dcache_req_we), 128'(mw != 3'd7));
                chk("req_be", 128'(dcache_req_be), 128'(m_be(mw, a)));
                if (mw != 3'd7) chk("req_wdata", 128'(dcache_req_wdata), 128'(m_wdata(mw, rd2[t*32 +: 32])));
                if (stall > 0) begin
                    stall--;
                    dcache_rsp_valid = 1'b1;
                    dcache_rsp_data  = $urandom;
                end else begin
                    dcache_req_ready = 1'b1;
                    if (mw != 3'd7) void'(q.pop_front());
                    else begin
                        pend = 1; wcnt = 1;
                        dly  = rnd ? $urandom_range(1, 3) : 1;
                    end
                    stall = rnd ? $urandom_range(0, 2) : 0;
                end
            end else begin
                chk("done_freeze", 128'(out_freeze), 128'(0));
                chk("done_req_valid", 128'(dcache_req_valid), 128'(0));
                chk("done_mem_result", out_mem_result, exp_mr);
                chk("done_alu", out_alu_result, alu);
                chk("done_valid", 128'(out_valid), 128'(vm));
                chk("done_ctrl", 128'({out_rd, out_rs1, out_rs2, out_wb, out_PC_next, out_warp_num}),
                    128'({rd, rs1, rs2, wb, pc, wn}));
                obs_mr = out_mem_result;
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        if (!done) chk("timeout", 128'(0), 128'(1));
        if (exp_frz >= 0) chk("freeze_cycles", 128'(frz), 128'(exp_frz));
    endtask

    initial begin
        logic [127:0] r;
        logic [2:0]   mr, mw;
        reset = 1'b0;
        in_alu_result = 128'h1234; in_rd2 = '0; in_mem_read = 3'd7; in_mem_write = 3'd7;
        in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; in_wb = 2'd1; in_PC_next = 32'h40;
        in_valid = 4'hF; in_warp_num = 3'd2;
        dcache_req_ready = 1'b0; dcache_rsp_valid = 1'b0; dcache_rsp_data = '0;
        #2;
        chk("rst_req_valid", 128'(dcache_req_valid), 128'(0));
        chk("rst_freeze", 128'(out_freeze), 128'(0));
        chk("rst_mem_result", out_mem_result, 128'(0));
        chk("rst_alu_pass", out_alu_result, 128'h1234);
        @(negedge clk);
        reset = 1'b1;

        // Non-memory instruction passes straight through
        @(negedge clk);
        in_alu_result = {96'h0, 32'h55}; in_rd = 5'd17; in_PC_next = 32'hCAFE_0000;
        #1;
        chk("nm_alu", 128'(out_alu_result[31:0]), 128'h55);
        chk("nm_freeze", 128'(out_freeze), 128'(0));
        chk("nm_req_valid", 128'(dcache_req_valid), 128'(0));
        chk("nm_mem_result", out_mem_result, 128'(0));
        chk("nm_rd", 128'(out_rd), 128'(17));
        chk("nm_pc", 128'(out_PC_next), 128'hCAFE_0000);
        // Load type with an empty mask is not a memory instruction
        @(negedge clk);
        in_mem_read = 3'd2; in_valid = 4'h0;
        #1;
        chk("nm_empty_mask_freeze", 128'(out_freeze), 128'(0));
        @(negedge clk);
        #1;
        chk("nm_empty_mask_idle", 128'(dcache_req_valid), 128'(0));
        in_mem_read = 3'd7;

        // LW, mask 1011
        run_mem({32'h10C, 32'h0, 32'h104, 32'h100}, '0, 3'd2, 3'd7, 4'b1011,
                {32'hA3, 32'h0, 32'hA1, 32'hA0}, 0, 1'b0, 7, r);
        chk("lw_result", r, {32'hA3, 32'h0, 32'hA1, 32'hA0});

        // Sub-word loads
        run_mem({96'h0, 32'h203}, '0, 3'd0, 3'd7, 4'b0001, {96'h0, 32'h80FF_FF7F}, 0, 1'b0, 3, r);
        chk("lb_result", 128'(r[31:0]), 128'hFFFF_FF80);
        run_mem({96'h0, 32'h203}, '0, 3'd4, 3'd7, 4'b0001, {96'h0, 32'h80FF_FF7F}, 0, 1'b0, 3, r);
        chk("lbu_result", 128'(r[31:0]), 128'h0000_0080);
        run_mem({96'h0, 32'h202}, '0, 3'd1, 3'd7, 4'b0001, {96'h0, 32'h80FF_FF7F}, 0, 1'b0, 3, r);
        chk("lh_result", 128'(r[31:0]), 128'hFFFF_80FF);

        // SB to all threads
        run_mem({4{32'h301}}, {4{32'h1234_5678}}, 3'd7, 3'd0, 4'hF, '0, 0, 1'b0, 5, r);
        chk("sb_result", r, 128'(0));

        // Five-cycle ready stall with spurious responses during REQ
        run_mem({32'h0, 32'h0, 32'h2004, 32'h2000}, '0, 3'd2, 3'd7, 4'b0011,
                {32'h0, 32'h0, 32'hBEEF_0001, 32'hBEEF_0000}, 5, 1'b0, 10, r);

        // Reset asserted while waiting for load data
        @(negedge clk);
        in_alu_result = {96'h0, 32'h40}; in_mem_read = 3'd2; in_mem_write = 3'd7; in_valid = 4'b0001;
        #1;
        chk("rw_cap_freeze", 128'(out_freeze), 128'(1));
        @(negedge clk);
        in_mem_read = 3'd7; dcache_req_ready = 1'b1;
        #1;
        chk("rw_req_valid", 128'(dcache_req_valid), 128'(1));
        @(negedge clk);
        dcache_req_ready = 1'b0;
        #1;
        chk("rw_wait_req", 128'(dcache_req_valid), 128'(0));
        chk("rw_wait_freeze", 128'(out_freeze), 128'(1));
        reset = 1'b0;
        #1;
        chk("rw_rst_freeze", 128'(out_freeze), 128'(0));
        chk("rw_rst_req", 128'(dcache_req_valid), 128'(0));
        chk("rw_rst_mem", out_mem_result, 128'(0));
        chk("rw_rst_alu", out_alu_result, {96'h0, 32'h40});
        @(negedge clk);
        reset = 1'b1;
        run_mem({4{32'h88}}, '0, 3'd2, 3'd7, 4'hF, {32'h4, 32'h3, 32'h2, 32'h1}, 0, 1'b0, 9, r);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                mr = 3'd7;
                mw = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: mr = 3'd0;
                    1: mr = 3'd1;
                    2: mr = 3'd2;
                    3: mr = 3'd4;
                    default: mr = 3'd5;
                endcase
                mw = 3'd7;
            end
            run_mem({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    mr, mw, 4'($urandom_range(1, 15)), {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 2), 1'b1, -1, r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
